// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder.
// ADDER_STAGE_T(W) builds the per-stage register type for a given operand width.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

`define ADDER_STAGE_T(W) struct packed { logic vld; logic c; logic [(W)-1:0] a; logic [(W)-1:0] b; logic [(W)-1:0] s; }

package adder_pkg;

   localparam int DEFAULT_WIDTH  = 8;
   localparam int DEFAULT_STAGES = 2;

   typedef `ADDER_STAGE_T(DEFAULT_WIDTH) stage_default_t;

   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

`endif

// File: rtl/pipelined_adder_slice.sv
// Combinational W-bit ripple-carry slice built from full-adder cells.
// Also exposes the carry into the MSB so the top slice can derive signed overflow.
module adder_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout,
   output logic         o_c_msb
);

   logic [W:0] w_c;

   always_comb begin
      w_c    = '0;
      o_sum  = '0;
      w_c[0] = i_cin;
      for (int i = 0; i < W; i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout  = w_c[W];
   assign o_c_msb = w_c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined ripple-carry adder, one carry-chain slice per register stage.
// Define ADDER_SUBTRACT_EN to add the `sub` input (a + ~b + 1, cin ignored).
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int SLICE = slice_w(WIDTH, STAGES);

   typedef `ADDER_STAGE_T(WIDTH) stage_t;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   stage_t           r_stg [STAGES];
   stage_t           w_nxt [STAGES];
   logic             r_ovf;
   logic             w_ovf_nxt;
   logic             w_adv;
   logic [WIDTH-1:0] w_b_in;
   logic             w_cin;

`ifdef ADDER_SUBTRACT_EN
   assign w_b_in = sub ? ~b : b;
   assign w_cin  = sub ? 1'b1 : cin;
`else
   assign w_b_in = b;
   assign w_cin  = cin;
`endif

   assign w_adv    = !r_stg[STAGES-1].vld || out_ready;
   assign in_ready = w_adv;

   // Stage 0 takes the operands; bubbles enter as all-zero so idle outputs read zero.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t           w_prv;
      logic [SLICE-1:0] w_s;
      logic             w_co;
      logic             w_cm;

      if (k == 0) begin : g_first
         assign w_prv = in_valid ? stage_t'({1'b1, w_cin, a, w_b_in, {WIDTH{1'b0}}}) : stage_t'('0);
      end else begin : g_next
         assign w_prv = r_stg[k-1];
      end

      adder_slice #(.W(SLICE)) u_slice (
         .i_a     (w_prv.a[k*SLICE +: SLICE]),
         .i_b     (w_prv.b[k*SLICE +: SLICE]),
         .i_cin   (w_prv.c),
         .o_sum   (w_s),
         .o_cout  (w_co),
         .o_c_msb (w_cm)
      );

      always_comb begin
         w_nxt[k]                     = w_prv;
         w_nxt[k].c                   = w_co;
         w_nxt[k].s[k*SLICE +: SLICE] = w_s;
      end

      if (k == STAGES-1) begin : g_last
         assign w_ovf_nxt = w_cm ^ w_co;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_stg[i] <= '0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int i = 0; i < STAGES; i++) begin
            r_stg[i] <= w_nxt[i];
         end
         r_ovf <= w_ovf_nxt;
      end
   end

   assign out_valid = r_stg[STAGES-1].vld;
   assign sum       = r_stg[STAGES-1].s;
   assign cout      = r_stg[STAGES-1].c;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed + random scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2).
module tb_pipelined_adder;

   localparam int W = 8;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef ADDER_SUBTRACT_EN
      .sub       (sub_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic ic, input logic isub);
      exp_t         r;
      logic [W:0]   t;
      logic [W-1:0] bb;
      logic         ci;
      bb  = isub ? ~ib : ib;
      ci  = isub ? 1'b1 : ic;
      t   = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, ci};
      r.s = t[W-1:0];
      r.c = t[W];
      r.o = (ia[W-1] == bb[W-1]) && (t[W-1] != ia[W-1]);
      return r;
   endfunction

   // Drive at negedge, score the transfers that the coming posedge performs, return #1 after it.
   task automatic step(input logic irst, input logic iv, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic ic, input logic isub, input logic ordy);
      exp_t e;
      @(negedge clk);
      rst       = irst;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub_i     = isub;
      out_ready = ordy;
      #1;
      if (!irst) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = q.pop_front();
               chk("sb_sum", 32'(sum), 32'(e.s));
               chk("sb_cout", 32'(cout), 32'(e.c));
               chk("sb_ovf", 32'(overflow), 32'(e.o));
            end
         end
         if (in_valid && in_ready) q.push_back(model(ia, ib, ic, isub));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ordy);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0; out_ready = 1'b1;
      step(1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);

      // 1: latency and signed overflow
      step(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
      chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
      idle(1'b1);
      chk("t1_valid_at_2", 32'(out_valid), 32'd1);
      chk("t1_sum", 32'(sum), 32'h80);
      chk("t1_cout", 32'(cout), 32'd0);
      chk("t1_ovf", 32'(overflow), 32'd1);
      idle(1'b1);
      chk("t1_single_result", 32'(out_valid), 32'd0);

      // 2: carry across the slice boundary and full wrap
      step(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("t2_sum_10", 32'(sum), 32'h10);
      idle(1'b1);
      chk("t2_sum_00", 32'(sum), 32'h00);
      chk("t2_cout", 32'(cout), 32'd1);
      chk("t2_ovf", 32'(overflow), 32'd0);
      idle(1'b1);

      // 3: back-to-back stream with a 3-cycle stall
      step(1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
      chk("t3_first_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'd3, 8'd3, 1'b0, 1'b0, 1'b0);
         chk("t3_stall_sum", 32'(sum), 32'h02);
         chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
      end
      step(1'b0, 1'b1, 8'd3, 8'd3, 1'b0, 1'b0, 1'b1);
      chk("t3_no_gap_a", 32'(out_valid), 32'd1);
      step(1'b0, 1'b1, 8'd4, 8'd4, 1'b0, 1'b0, 1'b1);
      chk("t3_no_gap_b", 32'(out_valid), 32'd1);
      idle(1'b1);
      chk("t3_no_gap_c", 32'(out_valid), 32'd1);
      chk("t3_last_sum", 32'(sum), 32'h08);
      idle(1'b1);
      idle(1'b1);
      chk("t3_drained", 32'(q.size()), 32'd0);

      // 4: reset with two ops in flight
      step(1'b0, 1'b1, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'd30, 8'd40, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      q.delete();
      chk("t4_out_valid", 32'(out_valid), 32'd0);
      chk("t4_sum", 32'(sum), 32'd0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         chk("t4_no_stale", 32'(out_valid), 32'd0);
      end
      step(1'b0, 1'b1, 8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
      idle(1'b1);
      chk("t4_new_sum", 32'(sum), 32'd11);
      idle(1'b1);
      idle(1'b1);

`ifdef ADDER_SUBTRACT_EN
      // 5: subtract
      step(1'b0, 1'b1, 8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
      chk("t5_sum_fe", 32'(sum), 32'hFE);
      chk("t5_cout_0", 32'(cout), 32'd0);
      chk("t5_ovf_0", 32'(overflow), 32'd0);
      idle(1'b1);
      chk("t5_sum_7f", 32'(sum), 32'h7F);
      chk("t5_ovf_1", 32'(overflow), 32'd1);
      idle(1'b1);
`endif

      // random traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
`ifdef ADDER_SUBTRACT_EN
              1'($urandom_range(0, 1)),
`else
              1'b0,
`endif
              1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 2 * S + 2; i++) idle(1'b1);
      chk("rand_drained", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
